// File: rtl/carry_select_serial_adder_pkg.sv
// Shared definitions for the nibble-serial carry-select adder.
// Contents: slice width, FSM state encoding and the slice-index width helper.
package carry_select_serial_adder_pkg;

   localparam int SLICE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   // Slice index width: clog2 of the slice count, never less than one bit.
   function automatic int idx_width(input int nibbles);
      int w;
      if (nibbles > 1) begin
         w = $clog2(nibbles);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/carry_select_serial_adder_if.sv
// Operand/result handshake bundle for carry_select_serial_adder.
// Signals: in_valid/in_ready/a/b/cin (operand side),
//          out_valid/out_ready/sum/cout (result side).
// Modports: slave = the adder, master = the driver/consumer around it.
interface carry_select_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/carry_select_serial_adder_dual.sv
// dual_ripple_adder_4bit: adds one 4-bit slice twice in parallel, once
// assuming carry-in 0 and once assuming carry-in 1.
// Ports: a, b (slice operands); cin0/sum0 (carry-in 0 result);
//        cin1/sum1 (carry-in 1 result). Output names line up with the
//        multiplexer_10to5 input ports.
module dual_ripple_adder_4bit
   import carry_select_serial_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   output logic               cin0,
   output logic [SLICE_W-1:0] sum0,
   output logic               cin1,
   output logic [SLICE_W-1:0] sum1
);

   // Both speculative sums; the carry out is the fifth bit of each.
   always_comb begin
      {cin0, sum0} = {1'b0, a} + {1'b0, b};
      {cin1, sum1} = {1'b0, a} + {1'b0, b} + 5'd1;
   end

endmodule

// File: rtl/multiplexer_10to5.sv
// multiplexer_10to5: carry-select stage. Picks one of two 5-bit
// {carry, sum} candidates.
// Ports: sel (0 -> cin0/sum0, 1 -> cin1/sum1); cout/sum (selected result).
module multiplexer_10to5 (
   input  logic       sel,
   input  logic       cin0,
   input  logic [3:0] sum0,
   input  logic       cin1,
   input  logic [3:0] sum1,
   output logic       cout,
   output logic [3:0] sum
);

   // Select the candidate matching the real incoming carry.
   always_comb begin
      if (sel) begin
         {cout, sum} = {cin1, sum1};
      end else begin
         {cout, sum} = {cin0, sum0};
      end
   end

endmodule

// File: rtl/carry_select_serial_adder.sv
// carry_select_serial_adder: nibble-serial adder. One 4-bit slice per
// cycle is added both ways (carry-in 0/1); the registered carry selects
// the real result. A WIDTH-bit add takes WIDTH/4 cycles in RUN.
// Ports: clk, rst (synchronous, active-high);
//        bus (slave modport): in_valid/in_ready/a/b/cin operand handshake,
//        out_valid/out_ready/sum/cout result handshake.
module carry_select_serial_adder
   import carry_select_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   carry_select_serial_adder_if.slave bus
);

   localparam int               NIBBLES  = WIDTH / SLICE_W;
   localparam int               IDX_W    = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
   localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

   state_t             state_r;
   state_t             state_nx_s;
   logic [IDX_W-1:0]   idx_r;
   logic               carry_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   sum_r;
   logic               cout_r;

   logic [31:0]        shamt_s;
   logic [SLICE_W-1:0] a_nib_s;
   logic [SLICE_W-1:0] b_nib_s;
   logic [SLICE_W-1:0] sum0_s;
   logic [SLICE_W-1:0] sum1_s;
   logic [SLICE_W-1:0] sel_sum_s;
   logic               c0_s;
   logic               c1_s;
   logic               sel_c_s;
   logic               last_s;

   // Current slice extraction; shifting avoids a wide variable index.
   always_comb begin
      shamt_s = 32'(idx_r) * SLICE_W;
      a_nib_s = SLICE_W'(a_r >> shamt_s);
      b_nib_s = SLICE_W'(b_r >> shamt_s);
      last_s  = (idx_r == LAST_IDX);
   end

   dual_ripple_adder_4bit u_dual (
      .a    (a_nib_s),
      .b    (b_nib_s),
      .cin0 (c0_s),
      .sum0 (sum0_s),
      .cin1 (c1_s),
      .sum1 (sum1_s)
   );

   multiplexer_10to5 u_mux (
      .sel  (carry_r),
      .cin0 (c0_s),
      .sum0 (sum0_s),
      .cin1 (c1_s),
      .sum1 (sum1_s),
      .cout (sel_c_s),
      .sum  (sel_sum_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.in_valid) state_nx_s = S_RUN;
            else              state_nx_s = S_IDLE;
         end
         S_RUN: begin
            if (last_s) state_nx_s = S_DONE;
            else        state_nx_s = S_RUN;
         end
         S_DONE: begin
            if (bus.out_ready) state_nx_s = S_IDLE;
            else               state_nx_s = S_DONE;
         end
         default: state_nx_s = S_IDLE;
      endcase
   end

   // Operand capture, per-slice sum/carry update and final carry out.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r   <= '0;
         carry_r <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= bus.cin;
                  idx_r   <= '0;
               end
            end
            S_RUN: begin
               sum_r   <= (sum_r & ~(NIB_MASK << shamt_s))
                        | (WIDTH'(sel_sum_s) << shamt_s);
               carry_r <= sel_c_s;
               if (last_s) begin
                  cout_r <= sel_c_s;
               end else begin
                  idx_r  <= idx_r + IDX_W'(1);
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_r == S_IDLE);
   assign bus.out_valid = (state_r == S_DONE);
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;

endmodule

// File: tb/tb_carry_select_serial_adder.sv
// Directed testbench for carry_select_serial_adder (WIDTH=16 and WIDTH=4).
module tb_carry_select_serial_adder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   carry_select_serial_adder_if #(.WIDTH(16)) bus16 ();
   carry_select_serial_adder_if #(.WIDTH(4))  bus4 ();

   carry_select_serial_adder #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   carry_select_serial_adder #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present operands in IDLE and step over the acceptance edge.
   task automatic start16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv);
      check_val({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd1);
      bus16.a        = av;
      bus16.b        = bv;
      bus16.cin      = cv;
      bus16.in_valid = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
   endtask

   // Count edges until out_valid, bounded so a stuck DUT still ends.
   task automatic wait_out16(output int cnt);
      cnt = 0;
      while (bus16.out_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
   endtask

   task automatic release16(input string tag);
      bus16.out_ready = 1'b1;
      tick();
      bus16.out_ready = 1'b0;
      check_val({tag, "_idle_rdy"}, 32'(bus16.in_ready), 32'd1);
      check_val({tag, "_idle_ov"},  32'(bus16.out_valid), 32'd0);
   endtask

   task automatic add16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec);
      int cnt;
      start16(tag, av, bv, cv);
      wait_out16(cnt);
      check_val({tag, "_lat"},  32'(cnt), 32'd4);
      check_val({tag, "_sum"},  32'(bus16.sum), 32'(es));
      check_val({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
      check_val({tag, "_ir"},   32'(bus16.in_ready), 32'd0);
      release16(tag);
   endtask

   initial begin
      int cnt;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0; bus16.cin = 1'b0;
      bus16.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
      bus4.out_ready = 1'b0;
      tick();
      tick();
      check_val("rst_in_ready",  32'(bus16.in_ready), 32'd1);
      check_val("rst_out_valid", 32'(bus16.out_valid), 32'd0);
      check_val("rst_sum",       32'(bus16.sum), 32'd0);
      check_val("rst_cout",      32'(bus16.cout), 32'd0);
      rst = 1'b0;
      tick();

      add16("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      add16("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      add16("v0f0f", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0);

      // Backpressure: result must hold while out_ready stays low.
      start16("bp", 16'h00FF, 16'h0001, 1'b0);
      wait_out16(cnt);
      check_val("bp_lat", 32'(cnt), 32'd4);
      for (int i = 0; i < 5; i++) begin
         check_val("bp_ov",   32'(bus16.out_valid), 32'd1);
         check_val("bp_ir",   32'(bus16.in_ready), 32'd0);
         check_val("bp_sum",  32'(bus16.sum), 32'h0100);
         check_val("bp_cout", 32'(bus16.cout), 32'd0);
         tick();
      end
      release16("bp");

      // in_valid left high with new operands during RUN/DONE is ignored.
      start16("hold", 16'h1111, 16'h2222, 1'b0);
      bus16.a        = 16'hAAAA;
      bus16.b        = 16'h5555;
      bus16.in_valid = 1'b1;
      wait_out16(cnt);
      check_val("hold_lat",  32'(cnt), 32'd4);
      check_val("hold_sum",  32'(bus16.sum), 32'h3333);
      check_val("hold_cout", 32'(bus16.cout), 32'd0);
      bus16.out_ready = 1'b1;
      tick();
      bus16.out_ready = 1'b0;
      check_val("hold_ir", 32'(bus16.in_ready), 32'd1);
      tick();
      bus16.in_valid = 1'b0;
      wait_out16(cnt);
      check_val("hold2_lat", 32'(cnt), 32'd4);
      check_val("hold2_sum", 32'(bus16.sum), 32'hFFFF);
      check_val("hold2_cout", 32'(bus16.cout), 32'd0);
      release16("hold2");

      // Reset on the second RUN edge aborts the add.
      start16("abort", 16'h1234, 16'h1111, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("abort_ov",   32'(bus16.out_valid), 32'd0);
      check_val("abort_sum",  32'(bus16.sum), 32'd0);
      check_val("abort_cout", 32'(bus16.cout), 32'd0);
      check_val("abort_ir",   32'(bus16.in_ready), 32'd1);
      add16("v8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

      // Single-slice instance.
      bus4.a = 4'hF; bus4.b = 4'hF; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      cnt = 0;
      while (bus4.out_valid !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check_val("w4_lat",  32'(cnt), 32'd1);
      check_val("w4_sum",  32'(bus4.sum), 32'hF);
      check_val("w4_cout", 32'(bus4.cout), 32'd1);
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      check_val("w4_ir", 32'(bus4.in_ready), 32'd1);
      bus4.a = 4'h3; bus4.b = 4'h4; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      check_val("w4b_ov",   32'(bus4.out_valid), 32'd1);
      check_val("w4b_sum",  32'(bus4.sum), 32'h7);
      check_val("w4b_cout", 32'(bus4.cout), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
